// File: rtl/mux_rr_n.sv
// N-channel registered stream multiplexer with static-select, fixed-priority and
// round-robin arbitration feeding a single valid/ready output register.
module mux_rr_n #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [SW-1:0]           sel,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SW-1:0]           out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    rr_q, rr_d;

    logic             gnt_vld_s;
    logic [SW-1:0]    gnt_idx_s;
    logic             can_load_s;
    logic             in_xfer_s;

    // Channel index base+off reduced modulo N_CH; base is always below N_CH.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return SW'((sum >= N_CH) ? (sum - N_CH) : sum);
    endfunction

    assign can_load_s = !out_valid_q || out_ready;
    assign in_xfer_s  = gnt_vld_s && can_load_s;

    // Arbiter: pick one valid channel according to mode.
    always_comb begin
        logic [SW-1:0] cand;
        logic          hit;
        gnt_vld_s = 1'b0;
        gnt_idx_s = {SW{1'b0}};
        cand      = {SW{1'b0}};
        hit       = 1'b0;
        case (mode)
            2'd0: begin
                for (int i = 0; i < N_CH; i++) begin
                    hit       = (int'(sel) == i) && in_valid[i];
                    gnt_idx_s = hit ? SW'(i) : gnt_idx_s;
                    gnt_vld_s = gnt_vld_s | hit;
                end
            end
            2'd1: begin
                for (int i = 0; i < N_CH; i++) begin
                    hit       = in_valid[i] && !gnt_vld_s;
                    gnt_idx_s = hit ? SW'(i) : gnt_idx_s;
                    gnt_vld_s = gnt_vld_s | in_valid[i];
                end
            end
            default: begin
                // Modes 2 and 3: search upward from the pointer with wrap.
                for (int k = 0; k < N_CH; k++) begin
                    cand      = wrap_add(rr_q, k);
                    hit       = in_valid[cand] && !gnt_vld_s;
                    gnt_idx_s = hit ? cand : gnt_idx_s;
                    gnt_vld_s = gnt_vld_s | in_valid[cand];
                end
            end
        endcase
    end

    // One-hot accept for the granted channel, suppressed during reset or stall.
    always_comb begin
        in_ready = {N_CH{1'b0}};
        if (rst_n && in_xfer_s) begin
            in_ready[gnt_idx_s] = 1'b1;
        end else begin
            in_ready = {N_CH{1'b0}};
        end
    end

    // Output register and round-robin pointer next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_d        = rr_q;
        if (in_xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
            out_ch_d    = gnt_idx_s;
            rr_d        = (gnt_idx_s == SW'(N_CH-1)) ? {SW{1'b0}} : (gnt_idx_s + SW'(1));
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_ch_q    <= {SW{1'b0}};
            rr_q        <= {SW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_q        <= rr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: a 4-channel instance for the main sequence and a
// 3-channel instance for the out-of-range static select.
module tb_mux_rr_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [1:0]  mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_rr_n #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_rr_n #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] ch, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_ch"},    32'(out_ch),    32'(ch));
        chk({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 2'd2;
        sel        = 2'd0;
        in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid   = 4'b0000;
        out_ready  = 1'b1;
        mode3      = 2'd0;
        sel3       = 2'd3;
        in_data3   = {8'hB2, 8'hB1, 8'hB0};
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;

        #2;
        chk_out("rst_init", 1'b0, 2'd0, 8'h00);
        chk("rst_init_rdy", 32'(in_ready), 32'h0);
        #10 rst_n = 1'b1;

        // Idle after reset
        step();
        chk("idle_rdy", 32'(in_ready), 32'h0);
        chk("idle_valid", 32'(out_valid), 32'h0);

        // Round-robin, all valid
        in_valid = 4'b1111;
        #1;
        chk("rr_first_rdy", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 8'hA0 + 8'(k % 4));
            chk($sformatf("rr%0d_rdy", k), 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
        end

        // Backpressure: holding channel 1
        out_ready = 1'b0;
        #1;
        chk("bp_rdy0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("bp%0d", k), 1'b1, 2'd1, 8'hA1);
            chk($sformatf("bp%0d_rdy", k), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'b0100);
        step();
        chk_out("bp_drain", 1'b1, 2'd2, 8'hA2);

        // Fixed priority
        mode = 2'd1;
        in_valid = 4'b1010;
        #1;
        chk("fp_rdy", 32'(in_ready), 32'b0010);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("fp%0d", k), 1'b1, 2'd1, 8'hA1);
            chk($sformatf("fp%0d_rdy", k), 32'(in_ready), 32'b0010);
        end
        in_valid = 4'b1000;
        #1;
        chk("fp_ch3_rdy", 32'(in_ready), 32'b1000);
        step();
        chk_out("fp_ch3", 1'b1, 2'd3, 8'hA3);

        // Mode switch: serve channel 2 in mode 1, then round-robin resumes at 3
        in_valid = 4'b1100;
        step();
        chk_out("ms_ch2", 1'b1, 2'd2, 8'hA2);
        mode = 2'd2;
        in_valid = 4'b1111;
        #1;
        chk("ms_rdy", 32'(in_ready), 32'b1000);
        step();
        chk_out("ms_ch3", 1'b1, 2'd3, 8'hA3);
        step();
        chk_out("ms_ch0", 1'b1, 2'd0, 8'hA0);

        // Static select, channel 2 not valid
        mode = 2'd0;
        sel = 2'd2;
        in_valid = 4'b1011;
        #1;
        chk("ss_rdy_none", 32'(in_ready), 32'h0);
        step();
        chk("ss_drain_valid", 32'(out_valid), 32'h0);
        step();
        chk("ss_idle_valid", 32'(out_valid), 32'h0);
        chk("ss_idle_rdy", 32'(in_ready), 32'h0);
        in_data[23:16] = 8'h5C;
        in_valid = 4'b1111;
        #1;
        chk("ss_rdy2", 32'(in_ready), 32'b0100);
        step();
        chk_out("ss_ch2", 1'b1, 2'd2, 8'h5C);

        // Asynchronous reset while a word is held
        #1 rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 2'd0, 8'h00);
        chk("arst_rdy", 32'(in_ready), 32'h0);
        in_valid = 4'b0000;
        mode = 2'd2;
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_rdy", 32'(in_ready), 32'h0);
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        in_valid = 4'b1111;
        #1;
        chk("post_rst_rr_rdy", 32'(in_ready), 32'b0001);
        step();
        chk_out("post_rst_ch0", 1'b1, 2'd0, 8'hA0);

        // Three channels, sel out of range
        in_valid3 = 3'b111;
        #1;
        chk("n3_sel3_rdy", 32'(in_ready3), 32'h0);
        step();
        chk("n3_sel3_valid", 32'(out_valid3), 32'h0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_rdy", 32'(in_ready3), 32'b100);
        step();
        chk("n3_sel2_valid", 32'(out_valid3), 32'h1);
        chk("n3_sel2_ch", 32'(out_ch3), 32'd2);
        chk("n3_sel2_data", 32'(out_data3), 32'hB2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
